// File: rtl/kf_bus_interface_control.sv
// kf_bus_interface_control
// Host-bus front end for KF-family peripherals. It qualifies the CPU strobes
// and synchronises them. It then produces a one-hot write pulse when a write
// ends, a one-hot read level while a read is active, and a pulse whenever a
// read and a write overlap.

module kf_bus_interface_control #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 2,
  parameter int NUM_REGS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select_n,
  input  logic                  read_enable_n,
  input  logic                  write_enable_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic [NUM_REGS-1:0]   write_strobe,
  output logic [NUM_REGS-1:0]   read_strobe,
  output logic                  read_start,
  output logic                  bus_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    wr_req_s;
  logic                    rd_req_s;
  logic [SYNC_STAGES-1:0]  wr_sync_r;
  logic [SYNC_STAGES-1:0]  rd_sync_r;
  logic                    wr_q_s;
  logic                    rd_q_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic [NUM_REGS-1:0]     write_strobe_s;
  logic [NUM_REGS-1:0]     read_strobe_s;
  logic                    read_start_s;
  logic                    bus_error_s;

  // One-hot register decode. An address beyond the register file selects nothing.
  function automatic logic [NUM_REGS-1:0] decode_reg(input logic [ADDR_WIDTH-1:0] addr);
    logic [NUM_REGS-1:0] hit;
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (addr == ADDR_WIDTH'(i));
    end
    return hit;
  endfunction

  // Read decode. An out-of-range address falls back to register 0, so a read
  // always selects exactly one register.
  function automatic logic [NUM_REGS-1:0] decode_read(input logic [ADDR_WIDTH-1:0] addr);
    logic [NUM_REGS-1:0] hit;
    hit    = decode_reg(addr);
    hit[0] = hit[0] | ~(|hit);
    return hit;
  endfunction

  assign wr_req_s = ~chip_select_n & ~write_enable_n;
  assign rd_req_s = ~chip_select_n & ~read_enable_n;
  assign wr_q_s   = wr_sync_r[SYNC_STAGES-1];
  assign rd_q_s   = rd_sync_r[SYNC_STAGES-1];

  // Synchroniser chains for the qualified write and read requests.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_sync_r <= '0;
      rd_sync_r <= '0;
    end else begin
      wr_sync_r[0] <= wr_req_s;
      rd_sync_r[0] <= rd_req_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wr_sync_r[i] <= wr_sync_r[i-1];
        rd_sync_r[i] <= rd_sync_r[i-1];
      end
    end
  end

  // Capture write data and address directly from the raw strobe.
  // By the time the synchronised strobe falls, both values are stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      internal_data_bus <= '0;
      wr_addr_r         <= '0;
    end else if (wr_req_s) begin
      internal_data_bus <= data_bus_in;
      wr_addr_r         <= address;
    end
  end

  // Bus-cycle state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. An overlap takes priority over ending the current cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_q_s && rd_q_s)       next_state_s = ST_ERROR;
        else if (wr_q_s)            next_state_s = ST_WRITE;
        else if (rd_q_s)            next_state_s = ST_READ;
        else                        next_state_s = ST_IDLE;
      end
      ST_WRITE: begin
        if (rd_q_s)                 next_state_s = ST_ERROR;
        else if (!wr_q_s)           next_state_s = ST_IDLE;
        else                        next_state_s = ST_WRITE;
      end
      ST_READ: begin
        if (wr_q_s)                 next_state_s = ST_ERROR;
        else if (!rd_q_s)           next_state_s = ST_IDLE;
        else                        next_state_s = ST_READ;
      end
      ST_ERROR: begin
        if (!wr_q_s && !rd_q_s)     next_state_s = ST_IDLE;
        else                        next_state_s = ST_ERROR;
      end
      default:                      next_state_s = ST_IDLE;
    endcase
  end

  // Output decode. Compute next-cycle values from the current transition,
  // so that every output leaves the block through a flop.
  always_comb begin
    if (state_r == ST_WRITE && next_state_s == ST_IDLE) begin
      write_strobe_s = decode_reg(wr_addr_r);
    end else begin
      write_strobe_s = '0;
    end

    if (next_state_s == ST_READ) begin
      if (state_r == ST_IDLE) begin
        read_strobe_s = decode_read(address);
      end else begin
        read_strobe_s = decode_read(rd_addr_r);
      end
    end else begin
      read_strobe_s = '0;
    end

    if (state_r == ST_IDLE && next_state_s == ST_READ) begin
      read_start_s = 1'b1;
    end else begin
      read_start_s = 1'b0;
    end

    if (state_r != ST_ERROR && next_state_s == ST_ERROR) begin
      bus_error_s = 1'b1;
    end else begin
      bus_error_s = 1'b0;
    end
  end

  // Freeze the read address on entry to READ.
  // Later address changes do not affect the selected register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr_r <= '0;
    end else if (state_r == ST_IDLE && next_state_s == ST_READ) begin
      rd_addr_r <= address;
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_strobe <= '0;
      read_strobe  <= '0;
      read_start   <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      write_strobe <= write_strobe_s;
      read_strobe  <= read_strobe_s;
      read_start   <= read_start_s;
      bus_error    <= bus_error_s;
    end
  end

endmodule

// File: tb/tb_kf_bus_interface_control.sv
// Testbench for kf_bus_interface_control.
// Two instances share the bus: one with the default 4 registers and one with
// NUM_REGS=3. Expected outputs come from a transaction-level timeline. For
// each bus cycle the bench computes the edge numbers where the pulses and
// levels must appear.

module tb_kf_bus_interface_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n  = 1'b1;
  logic       rd_n  = 1'b1;
  logic       wr_n  = 1'b1;
  logic [1:0] address = 2'd0;
  logic [7:0] din     = 8'd0;

  logic [7:0] db;
  logic [3:0] ws;
  logic [3:0] rs;
  logic       rst;
  logic       be;
  logic [7:0] db3;
  logic [2:0] ws3;
  logic [2:0] rs3;
  logic       rst3;
  logic       be3;

  kf_bus_interface_control dut (
    .clock(clock), .reset(reset), .chip_select_n(cs_n), .read_enable_n(rd_n),
    .write_enable_n(wr_n), .address(address), .data_bus_in(din),
    .internal_data_bus(db), .write_strobe(ws), .read_strobe(rs),
    .read_start(rst), .bus_error(be)
  );

  kf_bus_interface_control #(.NUM_REGS(3)) dut3 (
    .clock(clock), .reset(reset), .chip_select_n(cs_n), .read_enable_n(rd_n),
    .write_enable_n(wr_n), .address(address), .data_bus_in(din),
    .internal_data_bus(db3), .write_strobe(ws3), .read_strobe(rs3),
    .read_start(rst3), .bus_error(be3)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int edge_no = 0;

  // Observed outputs per edge, and the expected timeline keyed by edge number.
  logic [33:0] obs [int];
  logic [7:0]  model_db [int];
  logic [7:0]  model_data = 8'd0;
  logic [3:0]  exp_ws [int];
  logic [3:0]  exp_rs [int];
  logic [2:0]  exp_ws3 [int];
  logic [2:0]  exp_rs3 [int];
  bit          exp_rst [int];
  bit          exp_be [int];

  function automatic logic [3:0] hot_w(input logic [1:0] a, input int n);
    logic [3:0] r;
    r = 4'd0;
    if (int'(a) < n) r[a] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] hot_r(input logic [1:0] a, input int n);
    logic [3:0] r;
    r = 4'd0;
    if (int'(a) < n) r[a] = 1'b1;
    else r[0] = 1'b1;
    return r;
  endfunction

  function automatic logic [33:0] expect_at(input int e);
    logic [3:0] w, r;
    logic [2:0] w3, r3;
    logic       s, b;
    logic [7:0] d;
    w  = exp_ws.exists(e)  ? exp_ws[e]  : 4'd0;
    r  = exp_rs.exists(e)  ? exp_rs[e]  : 4'd0;
    w3 = exp_ws3.exists(e) ? exp_ws3[e] : 3'd0;
    r3 = exp_rs3.exists(e) ? exp_rs3[e] : 3'd0;
    s  = exp_rst.exists(e) ? exp_rst[e] : 1'b0;
    b  = exp_be.exists(e)  ? exp_be[e]  : 1'b0;
    d  = model_db.exists(e) ? model_db[e] : 8'd0;
    return {w, r, s, b, d, w3, r3, s, b, d};
  endfunction

  // Advance one clock edge. Update the data-capture model from the raw bus
  // levels at that edge, then record the outputs 1 ns later.
  task automatic cyc();
    logic raw_wr;
    raw_wr = !cs_n && !wr_n;
    @(posedge clock);
    edge_no++;
    if (reset) model_data = 8'd0;
    else if (raw_wr) model_data = din;
    model_db[edge_no] = model_data;
    #1;
    obs[edge_no] = {ws, rs, rst, be, db, ws3, rs3, rst3, be3, db3};
  endtask

  task automatic bus_idle_all();
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  // Write cycle. The write pulse is due SYNC_STAGES (2) edges after the first
  // edge that samples the request low.
  task automatic bus_write(input logic [7:0] d, input logic [1:0] a, input int len,
                           input int gap, input bit rel_cs);
    int n;
    logic [3:0] h;
    n = edge_no + 1 + len;
    exp_ws[n+2] = hot_w(a, 4);
    h = hot_w(a, 3);
    exp_ws3[n+2] = h[2:0];
    cs_n = 1'b0; wr_n = 1'b0; address = a; din = d;
    repeat (len) cyc();
    if (rel_cs) cs_n = 1'b1;
    else wr_n = 1'b1;
    repeat (gap) cyc();
    bus_idle_all();
  endtask

  // Read cycle. The address sampled on the READ-entry edge is the one held.
  // When a2_at is reached, the address changes to a2.
  task automatic bus_read(input logic [1:0] a, input int len, input int gap,
                          input logic [1:0] a2, input int a2_at, input bit rel_cs);
    int e0, m;
    logic [3:0] h;
    e0 = edge_no + 1;
    m  = e0 + len;
    exp_rst[e0+2] = 1'b1;
    for (int e = e0 + 2; e <= m + 1; e++) begin
      exp_rs[e] = hot_r(a, 4);
      h = hot_r(a, 3);
      exp_rs3[e] = h[2:0];
    end
    cs_n = 1'b0; rd_n = 1'b0; address = a;
    for (int i = 0; i < len; i++) begin
      if (i == a2_at) address = a2;
      cyc();
    end
    if (rel_cs) cs_n = 1'b1;
    else rd_n = 1'b1;
    repeat (gap) cyc();
    bus_idle_all();
  endtask

  task automatic test_reset();
    int s;
    s = edge_no + 1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (2) cyc();
    for (int e = s; e <= edge_no; e++) begin
      logic [33:0] x;
      x = expect_at(e);
      checks++;
      if (obs[e] !== x) $display("FAIL reset_state edge %0d got %h want %h", e, obs[e], x);
      else passes++;
    end
  endtask

  task automatic test_write_basic();
    int s;
    s = edge_no + 1;
    bus_write(8'hA5, 2'd2, 3, 4, 1'b0);
    for (int e = s; e <= edge_no; e++) begin
      logic [33:0] x;
      x = expect_at(e);
      checks++;
      if (obs[e] !== x) $display("FAIL write_basic edge %0d got %h want %h", e, obs[e], x);
      else passes++;
    end
    checks++;
    if (db !== 8'hA5) $display("FAIL write_basic_data got %h want a5", db);
    else passes++;
  endtask

  task automatic test_read_addr_change();
    int s;
    s = edge_no + 1;
    bus_read(2'd1, 4, 4, 2'd3, 3, 1'b0);
    for (int e = s; e <= edge_no; e++) begin
      logic [33:0] x;
      x = expect_at(e);
      checks++;
      if (obs[e] !== x) $display("FAIL read_addr_change edge %0d got %h want %h", e, obs[e], x);
      else passes++;
    end
  endtask

  task automatic test_overlap_error();
    int s, e0;
    s = edge_no + 1;
    // Simultaneous read and write requests.
    e0 = edge_no + 1;
    exp_be[e0+2] = 1'b1;
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; address = 2'd2; din = 8'h3C;
    repeat (2) cyc();
    bus_idle_all();
    repeat (5) cyc();
    // A read that arrives while a write is already in progress.
    e0 = edge_no + 1;
    exp_be[e0+4] = 1'b1;
    cs_n = 1'b0; wr_n = 1'b0; address = 2'd1; din = 8'hC3;
    repeat (2) cyc();
    rd_n = 1'b0;
    repeat (2) cyc();
    rd_n = 1'b1;
    repeat (2) cyc();
    bus_idle_all();
    repeat (5) cyc();
    for (int e = s; e <= edge_no; e++) begin
      logic [33:0] x;
      x = expect_at(e);
      checks++;
      if (obs[e] !== x) $display("FAIL overlap_error edge %0d got %h want %h", e, obs[e], x);
      else passes++;
    end
  endtask

  task automatic test_num_regs3();
    int s;
    s = edge_no + 1;
    bus_write(8'h5A, 2'd3, 2, 3, 1'b0);
    checks++;
    if (db3 !== 8'h5A) $display("FAIL nregs3_data got %h want 5a", db3);
    else passes++;
    bus_read(2'd3, 3, 3, 2'd3, 99, 1'b0);
    for (int e = s; e <= edge_no; e++) begin
      logic [33:0] x;
      x = expect_at(e);
      checks++;
      if (obs[e] !== x) $display("FAIL nregs3 edge %0d got %h want %h", e, obs[e], x);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_write();
    int s, n, pulses;
    s = edge_no + 1;
    cs_n = 1'b0; wr_n = 1'b0; address = 2'd1; din = 8'h77;
    repeat (2) cyc();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    n = edge_no + 1;
    exp_ws[n+2]  = 4'b0010;
    exp_ws3[n+2] = 3'b010;
    bus_idle_all();
    repeat (4) cyc();
    pulses = 0;
    for (int e = s; e <= edge_no; e++) begin
      logic [33:0] x;
      x = expect_at(e);
      if (obs[e][33:30] != 4'd0) pulses++;
      checks++;
      if (obs[e] !== x) $display("FAIL reset_mid_write edge %0d got %h want %h", e, obs[e], x);
      else passes++;
    end
    checks++;
    if (pulses != 1) $display("FAIL reset_mid_write_pulses got %0d want 1", pulses);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int s;
    s = edge_no + 1;
    bus_write(8'h11, 2'd0, 2, 2, 1'b0);
    bus_write(8'h22, 2'd1, 2, 4, 1'b1);
    for (int e = s; e <= edge_no; e++) begin
      logic [33:0] x;
      x = expect_at(e);
      checks++;
      if (obs[e] !== x) $display("FAIL back_to_back edge %0d got %h want %h", e, obs[e], x);
      else passes++;
    end
    checks++;
    if (db !== 8'h22) $display("FAIL back_to_back_data got %h want 22", db);
    else passes++;
  endtask

  task automatic test_random();
    int s;
    s = edge_no + 1;
    for (int t = 0; t < 40; t++) begin
      logic [1:0] a, a2;
      logic [7:0] d;
      int len, gap;
      bit rel_cs;
      a      = 2'($urandom_range(0, 3));
      a2     = 2'($urandom_range(0, 3));
      d      = 8'($urandom);
      len    = $urandom_range(1, 5);
      gap    = $urandom_range(2, 3);
      rel_cs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) bus_write(d, a, len, gap, rel_cs);
      else bus_read(a, len, gap, a2, 3, rel_cs);
    end
    repeat (4) cyc();
    for (int e = s; e <= edge_no; e++) begin
      logic [33:0] x;
      x = expect_at(e);
      checks++;
      if (obs[e] !== x) $display("FAIL random edge %0d got %h want %h", e, obs[e], x);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_addr_change();
    test_overlap_error();
    test_num_regs3();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
